snr_apb_monitor: RTL
====================

Name: snr_apb_monitor

Overview:
Parametrised APB3 slave that monitors NCH independent SNR sample streams from the demodulator channels. Per channel it holds the live value, min/max extrema and a block average over 2^AVG_LOG2 samples. It also raises a sticky below-threshold flag per channel and one level interrupt. It sits on the peripheral APB segment of the SoC as the successor of the single-channel SNR readout.

Parameters:
NCH, 4, number of SNR channels (1..8)
W, 17, SNR sample width (1..24)
AVG_LOG2, 4, average block length = 2^AVG_LOG2 samples (1..8)

Ports:
PCLK  in  1  system/APB clock
PRESET  in  1  synchronous active-high reset
PSEL  in  1  APB select
PADDR  in  10 [11:2]  word address
PENABLE  in  1  APB access phase
PWRITE  in  1  write strobe
PWDATA  in  32  write data
ECOREVNUM  in  4  ECO revision, reported in ID
PRDATA  out  32  read data
PREADY  out  1  always 1
PSLVERR  out  1  access-phase error for unmapped address
snr_valid  in  NCH  per-channel sample strobe
snr_data  in  NCH*W  packed samples, channel c at [c*W +: W]
irq  out  1  threshold interrupt

Behaviour:
- Clocking: all state on posedge PCLK. PRESET=1 is sampled synchronously and clears all state.
- Reset values: PRDATA=0, PSLVERR=0, irq=0, CTRL=0, THRESH=0, flags=0, LIVE=0, MIN=all-ones, MAX=0, AVG=0, accumulator=0, count=0. PREADY is constant 1.
- APB timing: zero wait states.
  - Read: PRDATA is registered in the setup phase (PSEL&~PENABLE&~PWRITE) and holds until the next read setup.
  - Write: committed in the access phase (PSEL&PENABLE&PWRITE).
  - PSLVERR: registered in setup, asserted during the access phase for unmapped addresses or channel index >= NCH, cleared otherwise. Writes to unmapped or read-only addresses are ignored.
- Register map (byte offsets):
  - 0x000 CTRL RW: bit0 EN; bit1 IRQ_EN; bit2 CLR_STATS is write-1 and self-clears, reading it returns 0.
  - 0x004 STATUS: [NCH-1:0] sticky flags, write-1-to-clear.
  - 0x008 THRESH RW: [W-1:0].
  - 0x00C ID RO: {16'h5A4E, ECOREVNUM, NCH[3:0], W[4:0] zero-extended to 8 bits}.
  - 0x040+16*c: LIVE / MIN / MAX / AVG at +0/+4/+8/+C, each zero-extended to 32 bits.
- Sample path (per channel): a sample is accepted when EN=1 and snr_valid[c]=1. On accept:
  - LIVE<=data.
  - MIN<=min(MIN,data); MAX<=max(MAX,data).
  - acc<=acc+data, with acc width W+AVG_LOG2 so it cannot overflow; count++.
  - When count==2^AVG_LOG2-1: AVG<=(acc+data)>>AVG_LOG2 (truncate), then acc<=0 and count<=0.
  - When EN=0, samples are dropped; acc and count hold.
- Averaging boundary:
  - EN 1->0 does not flush a partial block.
  - CLR_STATS clears acc, count, MIN (all-ones), MAX (0) and AVG. It does not clear LIVE.
- CLR_STATS coincident with an accepted sample: the clear applies first and the sample is then folded in. Result: MIN=MAX=data, acc=data, count=1.
- Threshold:
  - An accepted sample with data < THRESH (unsigned) sets flag[c] on the next edge.
  - A set coincident with a W1C clear of the same bit: the set wins.
  - THRESH=0 never sets a flag.
- irq: registered, irq <= IRQ_EN & |flags, so it follows the flags with 1 cycle of latency. Clearing IRQ_EN deasserts irq on the next edge.
- Read coherency: a read returns the register value before any same-edge sample update. Reset asserted mid-transfer aborts the transfer, and PRDATA returns to 0.

Decomposition:
- Package snr_apb_pkg: register offset localparams (CTRL, STATUS, THRESH, ID, CH_BASE, CH_STRIDE, LIVE/MIN/MAX/AVG sub-offsets), ID magic constant and CTRL bit indices.
- Sub-module snr_chan_stats (params W, AVG_LOG2): one channel's LIVE/MIN/MAX/AVG/acc/count plus the below-threshold pulse output. The top level generates NCH instances and owns the APB decode, CTRL, THRESH, flags and irq.

Test Plan:
1. Reset state: with PRESET high for 2 cycles, read ID -> 0x5A4E_0_4_11 (ECOREVNUM=0, NCH=4, W=17). Read CH0 MIN -> 0x1FFFF.
2. Averaging, AVG_LOG2=4, EN=1: send 16 samples 100..115 on ch1. AVG reads 107; count wraps and the 17th sample starts a new block. MIN=100, MAX=115, LIVE=115.
3. Threshold and irq: THRESH=500, IRQ_EN=1, send 499 on ch2. STATUS bit2 is set the next cycle and irq is high one cycle later. Write STATUS=0x4 -> irq low. A W1C coincident with another 499 keeps bit2 set.
4. CLR_STATS coincident with a sample of 42 on ch0: MIN=MAX=42, AVG=0.
5. EN=0: pulse snr_valid on ch3 with data 7 -> LIVE unchanged, count unchanged.
6. APB errors: read 0x0C0 (channel 8 when NCH=4) and 0x010 -> PSLVERR=1 in the access phase. Write to 0x040 -> ignored. PREADY stays 1 throughout.

Source files
------------

// File: rtl/snr_apb_pkg.sv
// Register map and ID constants shared by the SNR APB monitor and its channel blocks.
package snr_apb_pkg;

    localparam logic [11:0] CTRL_OFF   = 12'h000;
    localparam logic [11:0] STATUS_OFF = 12'h004;
    localparam logic [11:0] THRESH_OFF = 12'h008;
    localparam logic [11:0] ID_OFF     = 12'h00C;
    localparam logic [11:0] CH_BASE    = 12'h040;
    localparam logic [11:0] CH_STRIDE  = 12'h010;

    localparam logic [3:0] LIVE_OFF = 4'h0;
    localparam logic [3:0] MIN_OFF  = 4'h4;
    localparam logic [3:0] MAX_OFF  = 4'h8;
    localparam logic [3:0] AVG_OFF  = 4'hC;

    localparam logic [15:0] ID_MAGIC = 16'h5A4E;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLR_BIT    = 2;

endpackage

// File: rtl/snr_chan_stats.sv
// One SNR channel: live value, min/max extrema, block average over 2^AVG_LOG2
// samples, and a combinational below-threshold pulse for the accepted sample.
module snr_chan_stats #(
    parameter int W        = 17,
    parameter int AVG_LOG2 = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         accept_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] thresh_i,
    output logic [W-1:0] live_o,
    output logic [W-1:0] min_o,
    output logic [W-1:0] max_o,
    output logic [W-1:0] avg_o,
    output logic         below_o
);

    localparam int AW = W + AVG_LOG2;

    logic [W-1:0]        live_q, live_d, min_q, min_d, max_q, max_d, avg_q, avg_d;
    logic [W-1:0]        min_base, max_base;
    logic [AW-1:0]       acc_q, acc_d, acc_base, sum;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d, cnt_base;

    // A clear lands first; a coincident sample then folds into the cleared state.
    always_comb begin
        min_base = clr_i ? '1 : min_q;
        max_base = clr_i ? '0 : max_q;
        acc_base = clr_i ? '0 : acc_q;
        cnt_base = clr_i ? '0 : cnt_q;
        live_d   = live_q;
        min_d    = min_base;
        max_d    = max_base;
        acc_d    = acc_base;
        cnt_d    = cnt_base;
        avg_d    = clr_i ? '0 : avg_q;
        sum      = acc_base + AW'(data_i);
        if (accept_i) begin
            live_d = data_i;
            if (data_i < min_base) min_d = data_i;
            if (data_i > max_base) max_d = data_i;
            if (cnt_base == '1) begin
                avg_d = W'(sum >> AVG_LOG2);
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_base + AVG_LOG2'(1);
            end
        end
    end

    // NOTE: sequential state is only ever assigned with <= so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live_q <= '0;
            min_q  <= '1;
            max_q  <= '0;
            avg_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            live_q <= live_d;
            min_q  <= min_d;
            max_q  <= max_d;
            avg_q  <= avg_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign live_o  = live_q;
    assign min_o   = min_q;
    assign max_o   = max_q;
    assign avg_o   = avg_q;
    assign below_o = accept_i & (data_i < thresh_i);

endmodule

// File: rtl/snr_apb_monitor.sv
// APB3 slave monitoring NCH SNR sample streams: per-channel statistics, sticky
// below-threshold flags and a single level interrupt.
module snr_apb_monitor
    import snr_apb_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int W        = 17,
    parameter int AVG_LOG2 = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic [11:2]      PADDR,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PWDATA,
    input  logic [3:0]       ECOREVNUM,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [NCH-1:0]   snr_valid,
    input  logic [NCH*W-1:0] snr_data,
    output logic             irq
);

    localparam logic [3:0] NCH4 = 4'(NCH);
    localparam logic [4:0] W5   = 5'(W);

    logic [11:0] byte_addr, ch_rel, ch_idx;
    logic [3:0]  ch_sub;
    logic        in_ch, hit_ctrl, hit_status, hit_thresh, hit_id, mapped;
    logic        setup, rd_setup, wr_access, clr_stats;
    logic [31:0] rdata;
    logic [NCH-1:0] w1c, below;
    logic [W-1:0]   live_w [NCH];
    logic [W-1:0]   min_w  [NCH];
    logic [W-1:0]   max_w  [NCH];
    logic [W-1:0]   avg_w  [NCH];

    logic           en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d, pslverr_q, pslverr_d;
    logic [W-1:0]   thresh_q, thresh_d;
    logic [NCH-1:0] flags_q, flags_d;
    logic [31:0]    prdata_q, prdata_d;
    logic           unused_pwdata;

    assign byte_addr  = {PADDR, 2'b00};
    assign ch_rel     = byte_addr - CH_BASE;
    assign ch_idx     = ch_rel / CH_STRIDE;
    assign ch_sub     = ch_rel[3:0];
    assign in_ch      = byte_addr >= CH_BASE;
    assign hit_ctrl   = byte_addr == CTRL_OFF;
    assign hit_status = byte_addr == STATUS_OFF;
    assign hit_thresh = byte_addr == THRESH_OFF;
    assign hit_id     = byte_addr == ID_OFF;
    assign mapped     = hit_ctrl | hit_status | hit_thresh | hit_id | (in_ch && ch_idx < 12'(NCH));

    assign setup     = PSEL & ~PENABLE;
    assign rd_setup  = setup & ~PWRITE;
    assign wr_access = PSEL & PENABLE & PWRITE;
    assign clr_stats = wr_access & hit_ctrl & PWDATA[CTRL_CLR_BIT];
    assign w1c       = (wr_access && hit_status) ? PWDATA[NCH-1:0] : '0;
    assign unused_pwdata = ^PWDATA;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        snr_chan_stats #(.W(W), .AVG_LOG2(AVG_LOG2)) u_stats (
            .clk_i    (PCLK),
            .rst_i    (PRESET),
            .accept_i (en_q & snr_valid[c]),
            .clr_i    (clr_stats),
            .data_i   (snr_data[c*W +: W]),
            .thresh_i (thresh_q),
            .live_o   (live_w[c]),
            .min_o    (min_w[c]),
            .max_o    (max_w[c]),
            .avg_o    (avg_w[c]),
            .below_o  (below[c])
        );
    end

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (hit_ctrl) begin
            rdata[CTRL_EN_BIT]     = en_q;
            rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
        if (hit_status) rdata[NCH-1:0] = flags_q;
        if (hit_thresh) rdata[W-1:0]   = thresh_q;
        if (hit_id)     rdata = {ID_MAGIC, ECOREVNUM, NCH4, 3'b000, W5};
        for (int c = 0; c < NCH; c++) begin
            if (in_ch && ch_idx == 12'(c)) begin
                case (ch_sub)
                    LIVE_OFF: rdata = 32'(live_w[c]);
                    MIN_OFF:  rdata = 32'(min_w[c]);
                    MAX_OFF:  rdata = 32'(max_w[c]);
                    AVG_OFF:  rdata = 32'(avg_w[c]);
                    default:  rdata = '0;
                endcase
            end
        end
    end

    // A sample-set flag wins over a coincident write-1-to-clear of the same bit.
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (wr_access && hit_ctrl) begin
            en_d     = PWDATA[CTRL_EN_BIT];
            irq_en_d = PWDATA[CTRL_IRQ_EN_BIT];
        end
        if (wr_access && hit_thresh) thresh_d = PWDATA[W-1:0];
        flags_d   = (flags_q & ~w1c) | below;
        irq_d     = irq_en_q & (|flags_q);
        prdata_d  = rd_setup ? rdata : prdata_q;
        pslverr_d = setup & ~mapped;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            thresh_q  <= '0;
            flags_q   <= '0;
            irq_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            thresh_q  <= thresh_d;
            flags_q   <= flags_d;
            irq_q     <= irq_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;
    assign PREADY  = 1'b1;
    assign irq     = irq_q;

endmodule
